// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns the debounced button level into PRESS / RELEASE / LONG / REPEAT
// events. Events go out through a single-entry valid/ready register, and a
// sticky overflow flag records any event that had to be dropped.
// Optional feature: define BTN_AUTOREPEAT_EN to compile in the auto-repeat
// state. Without it, the FSM parks in LONGHELD after LONG until release.

module button_event_decoder #(
    parameter logic ACTIVE_LEVEL  = 1'b1,
    parameter int   CNT_W         = 26,
    parameter int   LONG_CYCLES   = 38000000,
    parameter int   REPEAT_CYCLES = 7600000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       db_in,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       pressed,
    output logic       overflow
);

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    // Terminal counts for the two hold phases.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HELD     = 2'd1,
`ifdef BTN_AUTOREPEAT_EN
        ST_RPT      = 2'd2
`else
        ST_LONGHELD = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evtValid_q;
    logic [1:0]       evtCode_q;
    logic             pressed_q;
    logic             overflow_q;

    logic             act;
    logic [CNT_W-1:0] cntTarget;
    logic             atTarget;
    logic             genValid;
    logic [1:0]       genCode;

    // Next state, next count and the event generated this cycle.
    // A release always outranks a threshold hit on the same edge.
    always_comb begin
        act       = (db_in == ACTIVE_LEVEL);
        state_d   = state_q;
        cnt_d     = cnt_q;
        genValid  = 1'b0;
        genCode   = EVT_PRESS;
        cntTarget = (state_q == ST_HELD) ? LONG_LAST : REPEAT_LAST;
        atTarget  = (cnt_q == cntTarget);

        case (state_q)
            ST_IDLE: begin
                if (act) begin
                    state_d  = ST_HELD;
                    cnt_d    = '0;
                    genValid = 1'b1;
                    genCode  = EVT_PRESS;
                end
            end
            ST_HELD: begin
                if (!act) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    genValid = 1'b1;
                    genCode  = EVT_RELEASE;
                end else if (atTarget) begin
                    cnt_d    = '0;
                    genValid = 1'b1;
                    genCode  = EVT_LONG;
`ifdef BTN_AUTOREPEAT_EN
                    state_d  = ST_RPT;
`else
                    state_d  = ST_LONGHELD;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            ST_RPT: begin
                if (!act) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    genValid = 1'b1;
                    genCode  = EVT_RELEASE;
                end else if (atTarget) begin
                    cnt_d    = '0;
                    genValid = 1'b1;
                    genCode  = EVT_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`else
            ST_LONGHELD: begin
                if (!act) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    genValid = 1'b1;
                    genCode  = EVT_RELEASE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and the output register with its drop/overflow rule.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            evtValid_q <= 1'b0;
            evtCode_q  <= EVT_PRESS;
            pressed_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= (state_d != ST_IDLE);
            if (genValid && (!evtValid_q || evt_ready)) begin
                evtValid_q <= 1'b1;
                evtCode_q  <= genCode;
            end else if (genValid) begin
                overflow_q <= 1'b1;
            end else if (evt_ready) begin
                evtValid_q <= 1'b0;
            end
        end
    end

    assign evt_valid = evtValid_q;
    assign evt_code  = evtCode_q;
    assign pressed   = pressed_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed self-checking bench for button_event_decoder with
// LONG_CYCLES=8 and REPEAT_CYCLES=4. Expectations follow BTN_AUTOREPEAT_EN.

module tb_button_event_decoder;

    localparam logic [1:0] PRESS   = 2'b00;
    localparam logic [1:0] RELEASE = 2'b01;
    localparam logic [1:0] LONG    = 2'b10;
    localparam logic [1:0] REPEAT  = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       db_in;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       pressed;
    logic       overflow;

    int vectors = 0;
    int errors  = 0;

    button_event_decoder #(
        .ACTIVE_LEVEL (1'b1),
        .CNT_W        (26),
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .db_in    (db_in),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_ready(evt_ready),
        .pressed  (pressed),
        .overflow (overflow)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // One comparison: count it, and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Checks evt_valid, and evt_code only when an event is expected.
    task automatic checkEvent(input string tag, input logic expValid, input logic [1:0] expCode);
        checkOutput({tag, "_valid"}, {3'b0, evt_valid}, {3'b0, expValid});
        if (expValid)
            checkOutput({tag, "_code"}, {2'b0, evt_code}, {2'b0, expCode});
    endtask

    // Drive inputs, then let one rising edge pass and settle.
    task automatic applyStimulus(input logic db, input logic rdy, input logic rst);
        db_in     = db;
        evt_ready = rdy;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    // Directed scenario sequence.
    initial begin
        logic       expV;
        logic [1:0] expC;

        // Reset state.
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rst_valid",    {3'b0, evt_valid}, 4'h0);
        checkOutput("rst_code",     {2'b0, evt_code},  4'h0);
        checkOutput("rst_pressed",  {3'b0, pressed},   4'h0);
        checkOutput("rst_overflow", {3'b0, overflow},  4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("idle", 1'b0, PRESS);

        // Short press of three cycles.
        $display("[TB] short press");
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkEvent("sp_press", 1'b1, PRESS);
        checkOutput("sp_pressed0", {3'b0, pressed}, 4'h1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkEvent("sp_hold1", 1'b0, PRESS);
        checkOutput("sp_pressed1", {3'b0, pressed}, 4'h1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkEvent("sp_hold2", 1'b0, PRESS);
        checkOutput("sp_pressed2", {3'b0, pressed}, 4'h1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("sp_release", 1'b1, RELEASE);
        checkOutput("sp_pressed3", {3'b0, pressed}, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("sp_after", 1'b0, PRESS);

        // Long hold: edges 0..20 sample the button pressed.
        $display("[TB] long hold");
        for (int k = 0; k <= 20; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            expV = (k == 0) || (k == 8);
            expC = (k == 0) ? PRESS : LONG;
`ifdef BTN_AUTOREPEAT_EN
            if (k > 8 && ((k - 8) % 4) == 0) begin
                expV = 1'b1;
                expC = REPEAT;
            end
`endif
            checkEvent($sformatf("lh_e%0d", k), expV, expC);
            checkOutput($sformatf("lh_pressed%0d", k), {3'b0, pressed}, 4'h1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("lh_release", 1'b1, RELEASE);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("lh_after", 1'b0, PRESS);
        checkOutput("lh_overflow", {3'b0, overflow}, 4'h0);

        // Backpressure: PRESS held, LONG dropped, overflow sticky.
        $display("[TB] backpressure");
        for (int k = 0; k <= 9; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkEvent($sformatf("bp_e%0d", k), 1'b1, PRESS);
            checkOutput($sformatf("bp_ovf%0d", k), {3'b0, overflow}, (k >= 8) ? 4'h1 : 4'h0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkEvent("bp_accept", 1'b0, PRESS);
        checkOutput("bp_ovf_acc", {3'b0, overflow}, 4'h1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("bp_release", 1'b1, RELEASE);
        checkOutput("bp_ovf_rel", {3'b0, overflow}, 4'h1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("bp_after", 1'b0, PRESS);
        checkOutput("bp_ovf_after", {3'b0, overflow}, 4'h1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("bp_ovf_reset", {3'b0, overflow}, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Accept-and-reload: RELEASE replaces accepted PRESS without a bubble.
        $display("[TB] accept and reload");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEvent("ar_press", 1'b1, PRESS);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEvent("ar_pending", 1'b1, PRESS);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("ar_reload", 1'b1, RELEASE);
        checkOutput("ar_overflow", {3'b0, overflow}, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("ar_after", 1'b0, PRESS);

        // Reset mid-hold with a pending PRESS, then restart while still held.
        $display("[TB] reset mid-hold");
        for (int k = 0; k <= 4; k++)
            applyStimulus(1'b1, 1'b0, 1'b0);
        checkEvent("rm_pending", 1'b1, PRESS);
        checkOutput("rm_pressed_pre", {3'b0, pressed}, 4'h1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("rm_valid",    {3'b0, evt_valid}, 4'h0);
        checkOutput("rm_code",     {2'b0, evt_code},  4'h0);
        checkOutput("rm_pressed",  {3'b0, pressed},   4'h0);
        checkOutput("rm_overflow", {3'b0, overflow},  4'h0);
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            expV = (k == 0) || (k == 8);
            expC = (k == 0) ? PRESS : LONG;
            checkEvent($sformatf("rm_e%0d", k), expV, expC);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("rm_release", 1'b1, RELEASE);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("rm_after", 1'b0, PRESS);

        // Release sampled on the LONG threshold edge: RELEASE only.
        $display("[TB] release at threshold");
        for (int k = 0; k <= 7; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkEvent($sformatf("rt_e%0d", k), (k == 0), PRESS);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("rt_release", 1'b1, RELEASE);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("rt_after1", 1'b0, PRESS);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEvent("rt_after2", 1'b0, PRESS);
        checkOutput("rt_overflow", {3'b0, overflow}, 4'h0);
        checkOutput("rt_pressed",  {3'b0, pressed},  4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
